// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: traps, mret returns and Zicsr access to the machine CSRs.
// Optional trap counter CSR at 0x7C0 is built when TRAP_CNT_EN is defined.
module trap_ctrl #(
    parameter logic [1:0]  NOT_EXCEPTION = 2'b00,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        illegal_instr,
    input  logic        is_ecall,
    input  logic        is_ebreak,
    input  logic        is_mret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [1:0]  exception_cause,
    output logic [31:0] exception_handling_addr,
    output logic        ret_valid,
    output logic [31:0] ret_target,
    output logic        trap_flush
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_TRAPCNT = 12'h7C0;

    typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

    state_t      state_q;
    logic        mie_q, mpie_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q;
    logic [1:0]  cause_q;
    logic [31:0] haddr_q, ret_target_q;
    logic        ret_valid_q, flush_q;
`ifdef TRAP_CNT_EN
    logic [31:0] trap_cnt_q;
`endif

    logic        accept, any_trap, trap_take, mret_take, csr_we;
    logic [1:0]  cause_d;
    logic [31:0] mcause_d, csr_wval_d;

    assign accept    = valid && !stall && (state_q == IDLE);
    assign any_trap  = illegal_instr || is_ecall || is_ebreak;
    assign trap_take = accept && any_trap;
    assign mret_take = accept && !any_trap && is_mret;
    // Set/clear with a zero operand is a pure read and must not write.
    assign csr_we    = accept && !any_trap && !is_mret && (csr_op != 2'b00) &&
                       ((csr_op == 2'b01) || (csr_wdata != 32'h0));

    always_comb begin
        cause_d  = 2'b11;
        mcause_d = 32'd3;
        if (illegal_instr) begin
            cause_d  = 2'b01;
            mcause_d = 32'd2;
        end else if (is_ecall) begin
            cause_d  = 2'b10;
            mcause_d = 32'd11;
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
`ifdef TRAP_CNT_EN
            ADDR_TRAPCNT: csr_rdata = trap_cnt_q;
`endif
            default:      csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        csr_wval_d = csr_wdata;
        case (csr_op)
            2'b10:   csr_wval_d = csr_rdata | csr_wdata;
            2'b11:   csr_wval_d = csr_rdata & ~csr_wdata;
            default: csr_wval_d = csr_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mtvec_q      <= MTVEC_RESET & ~32'h3;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            cause_q      <= NOT_EXCEPTION;
            haddr_q      <= 32'h0;
            ret_valid_q  <= 1'b0;
            ret_target_q <= 32'h0;
            flush_q      <= 1'b0;
`ifdef TRAP_CNT_EN
            trap_cnt_q   <= 32'h0;
`endif
        end else begin
            // Redirect outputs are single-cycle pulses unless re-armed below.
            cause_q      <= NOT_EXCEPTION;
            haddr_q      <= 32'h0;
            ret_valid_q  <= 1'b0;
            ret_target_q <= 32'h0;
            flush_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_take) begin
                        state_q  <= TRAP;
                        cause_q  <= cause_d;
                        haddr_q  <= mtvec_q;
                        flush_q  <= 1'b1;
                        mepc_q   <= pc & ~32'h3;
                        mcause_q <= mcause_d;
                        mpie_q   <= mie_q;
                        mie_q    <= 1'b0;
`ifdef TRAP_CNT_EN
                        trap_cnt_q <= trap_cnt_q + 32'd1;
`endif
                    end else if (mret_take) begin
                        state_q      <= RET;
                        ret_valid_q  <= 1'b1;
                        ret_target_q <= mepc_q;
                        flush_q      <= 1'b1;
                        mie_q        <= mpie_q;
                        mpie_q       <= 1'b1;
                    end else if (csr_we) begin
                        case (csr_addr)
                            ADDR_MSTATUS: begin
                                mie_q  <= csr_wval_d[3];
                                mpie_q <= csr_wval_d[7];
                            end
                            ADDR_MTVEC:   mtvec_q  <= csr_wval_d & ~32'h3;
                            ADDR_MEPC:    mepc_q   <= csr_wval_d & ~32'h3;
                            ADDR_MCAUSE:  mcause_q <= csr_wval_d;
`ifdef TRAP_CNT_EN
                            ADDR_TRAPCNT: trap_cnt_q <= csr_wval_d;
`endif
                            default: ;
                        endcase
                    end
                end
                TRAP:    state_q <= IDLE;
                RET:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign exception_cause         = cause_q;
    assign exception_handling_addr = haddr_q;
    assign ret_valid               = ret_valid_q;
    assign ret_target              = ret_target_q;
    assign trap_flush              = flush_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Table-driven bench for trap_ctrl: csr_rdata checked in the driven cycle, redirect outputs
// checked one edge later through an expected-result queue.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid, stall, illegal_instr, is_ecall, is_ebreak, is_mret;
    logic [31:0] pc, csr_wdata, csr_rdata, exception_handling_addr, ret_target;
    logic [1:0]  csr_op, exception_cause;
    logic [11:0] csr_addr;
    logic        ret_valid, trap_flush;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .valid(valid), .stall(stall), .pc(pc),
        .illegal_instr(illegal_instr), .is_ecall(is_ecall), .is_ebreak(is_ebreak),
        .is_mret(is_mret), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .exception_cause(exception_cause),
        .exception_handling_addr(exception_handling_addr), .ret_valid(ret_valid),
        .ret_target(ret_target), .trap_flush(trap_flush)
    );

    localparam logic [3:0] E_NONE = 4'b0000, E_ILL = 4'b1000, E_ECALL = 4'b0100,
                           E_EBRK = 4'b0010, E_MRET = 4'b0001, E_ILLEC = 4'b1100;

    typedef struct {
        logic        rst, v, st;
        logic [31:0] pc;
        logic [3:0]  ev;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd, exp_rd;
        logic [1:0]  exp_cause;
        logic [31:0] exp_haddr;
        logic        exp_rv;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t        vecs[$];
    logic [67:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(logic r, logic v, logic st, logic [31:0] p, logic [3:0] ev,
                                logic [1:0] op, logic [11:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic [1:0] c, logic [31:0] ha,
                                logic rv, logic [31:0] rt);
        vec_t x;
        x.rst = r; x.v = v; x.st = st; x.pc = p; x.ev = ev; x.op = op; x.addr = a;
        x.wd = wd; x.exp_rd = rd; x.exp_cause = c; x.exp_haddr = ha; x.exp_rv = rv;
        x.exp_rt = rt;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        logic [67:0] e;
        @(negedge clk);
        rst = x.rst; valid = x.v; stall = x.st; pc = x.pc;
        {illegal_instr, is_ecall, is_ebreak, is_mret} = x.ev;
        csr_op = x.op; csr_addr = x.addr; csr_wdata = x.wd;
        #1 check("csr_rdata", idx, csr_rdata, x.exp_rd);
        exp_q.push_back({x.exp_cause, x.exp_haddr, x.exp_rv, x.exp_rt,
                         (x.exp_cause != 2'b00) || x.exp_rv});
        @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard (vector %0d): queue empty", idx);
        end else begin
            e = exp_q.pop_front();
            check("exception_cause", idx, {30'h0, exception_cause}, {30'h0, e[67:66]});
            check("handling_addr", idx, exception_handling_addr, e[65:34]);
            check("ret_valid", idx, {31'h0, ret_valid}, {31'h0, e[33]});
            check("ret_target", idx, ret_target, e[32:1]);
            check("trap_flush", idx, {31'h0, trap_flush}, {31'h0, e[0]});
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; stall = 1'b0; pc = '0; illegal_instr = 1'b0;
        is_ecall = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0; csr_op = 2'b00;
        csr_addr = 12'h305; csr_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cause", -1, {30'h0, exception_cause}, 32'h0);
        check("reset_haddr", -1, exception_handling_addr, 32'h0);
        check("reset_ret_valid", -1, {31'h0, ret_valid}, 32'h0);
        check("reset_ret_target", -1, ret_target, 32'h0);
        check("reset_flush", -1, {31'h0, trap_flush}, 32'h0);
        check("reset_mtvec", -1, csr_rdata, 32'h0000_0100);

        //               rst v  st pc          ev       op     addr    wdata          rd            cause  haddr         rv rt
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h305, 32'h0,         32'h100,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b01, 12'h305, 32'h2003,      32'h100,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h305, 32'h0,         32'h2000,     2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h44,    E_ECALL, 2'b00, 12'h341, 32'h0,         32'h0,        2'b10, 32'h2000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     E_NONE,  2'b00, 12'h341, 32'h0,         32'h44,       2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h342, 32'h0,         32'd11,       2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b10, 12'h300, 32'h8,         32'h0,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h300, 32'h0,         32'h8,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h80,    E_ILL,   2'b00, 12'h342, 32'h0,         32'd11,       2'b01, 32'h2000, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h90,    E_EBRK,  2'b00, 12'h342, 32'h0,         32'd2,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h300, 32'h0,         32'h80,       2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h342, 32'h0,         32'd2,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_MRET,  2'b00, 12'h341, 32'h0,         32'h80,       2'b00, 32'h0,    1, 32'h80));
        vecs.push_back(mk(0, 0, 0, 32'h0,     E_NONE,  2'b00, 12'h300, 32'h0,         32'h88,       2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h100,   E_ILLEC, 2'b01, 12'h305, 32'hFFFF_0000, 32'h2000,     2'b01, 32'h2000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     E_NONE,  2'b00, 12'h305, 32'h0,         32'h2000,     2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h342, 32'h0,         32'd2,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b01, 12'h341, 32'h123,       32'h100,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b10, 12'h341, 32'h10,        32'h120,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b11, 12'h341, 32'h20,        32'h130,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h341, 32'h0,         32'h110,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b01, 12'h7FF, 32'h5,         32'h0,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h7FF, 32'h0,         32'h0,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b01, 12'h300, 32'hFFFF_FFFF, 32'h80,       2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h300, 32'h0,         32'h88,       2'b00, 32'h0,    0, 32'h0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 1, 32'h200, E_EBRK, 2'b00, 12'h341, 32'h0,     32'h110,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h200,   E_EBRK,  2'b00, 12'h341, 32'h0,         32'h110,      2'b11, 32'h2000, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h0,     E_NONE,  2'b00, 12'h342, 32'h0,         32'd3,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h300,   E_ECALL, 2'b00, 12'h305, 32'h0,         32'h2000,     2'b10, 32'h2000, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h300,   E_ECALL, 2'b00, 12'h305, 32'h0,         32'h2000,     2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h305, 32'h0,         32'h100,      2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h342, 32'h0,         32'h0,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h7,     E_ECALL, 2'b00, 12'h341, 32'h0,         32'h0,        2'b10, 32'h100,  0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b00, 12'h341, 32'h0,         32'h4,        2'b00, 32'h0,    0, 32'h0));
`ifdef TRAP_CNT_EN
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b01, 12'h7C0, 32'hFFFF_FFFF, 32'h1,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h10,    E_ECALL, 2'b00, 12'h7C0, 32'h0,         32'hFFFF_FFFF, 2'b10, 32'h100, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     E_NONE,  2'b00, 12'h7C0, 32'h0,         32'h0,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h20,    E_ECALL, 2'b00, 12'h7C0, 32'h0,         32'h0,        2'b10, 32'h100,  0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     E_NONE,  2'b00, 12'h7C0, 32'h0,         32'h1,        2'b00, 32'h0,    0, 32'h0));
`else
        vecs.push_back(mk(0, 1, 0, 32'h0,     E_NONE,  2'b01, 12'h7C0, 32'hFFFF_FFFF, 32'h0,        2'b00, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h10,    E_ECALL, 2'b00, 12'h7C0, 32'h0,         32'h0,        2'b10, 32'h100,  0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     E_NONE,  2'b00, 12'h7C0, 32'h0,         32'h0,        2'b00, 32'h0,    0, 32'h0));
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Random back-to-back mtvec writes: each read must see the previous aligned write.
        begin
            logic [31:0] model_mtvec;
            logic [31:0] w;
            model_mtvec = 32'h100;
            for (int i = 0; i < 8; i++) begin
                w = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
                apply(mk(0, 1, 0, 32'h0, E_NONE, 2'b01, 12'h305, w, model_mtvec,
                         2'b00, 32'h0, 0, 32'h0), 100 + i);
                model_mtvec = w & ~32'h3;
            end
            apply(mk(0, 1, 0, 32'h0, E_NONE, 2'b00, 12'h305, 32'h0, model_mtvec,
                     2'b00, 32'h0, 0, 32'h0), 108);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
